// File: rtl/present80_dec_core.sv
// ---------------------------------------------------------------------------
// present80_dec_core
//   Iterative PRESENT-80 block decryption, one round per clock.
//   A cold key first runs the forward key schedule (31 cycles) to reach K32.
//   The core then decrypts for 31 rounds while unwinding the schedule back to
//   K1, and finishes with a whitening cycle. When KEY_CACHE is set, the last
//   key and its K32 are kept, so a repeated key skips the expansion phase.
//
// Ports
//   clk    in   1   system clock, rising edge
//   rst    in   1   synchronous active-high reset
//   start  in   1   request, sampled only while idle
//   busy   out  1   operation in progress
//   done   out  1   one-cycle pulse, pt valid
//   ct     in  64   ciphertext, ct[63:56] is byte 0
//   key    in  80   key, key[79:72] is byte 0
//   pt     out 64   plaintext, held until the next completion
// ---------------------------------------------------------------------------
module present80_dec_core #(
  parameter int KEY_CACHE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic [63:0] ct,
  input  logic [79:0] key,
  output logic [63:0] pt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_KEXP  = 2'd1;
  localparam logic [1:0] S_DEC   = 2'd2;
  localparam logic [1:0] S_FINAL = 2'd3;

  // Nibble tables, entry 0 in the top nibble.
  localparam logic [63:0] SBOX     = 64'hC56B90AD3EF84712;
  localparam logic [63:0] INV_SBOX = 64'h5EF8C12DB463079A;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX[60 - 4 * int'(x) +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    return INV_SBOX[60 - 4 * int'(x) +: 4];
  endfunction

  // Forward schedule step: rotate left 61, S-box top nibble, mix in round count.
  function automatic logic [79:0] fwd_update(input logic [79:0] k,
                                             input logic [4:0]  r);
    logic [79:0] t;
    t          = {k[18:0], k[79:19]};
    t[79:76]   = sbox(t[79:76]);
    t[19:15]   = t[19:15] ^ r;
    return t;
  endfunction

  // Exact inverse of fwd_update for the same round count.
  function automatic logic [79:0] inv_update(input logic [79:0] k,
                                             input logic [4:0]  r);
    logic [79:0] t;
    t          = k;
    t[19:15]   = t[19:15] ^ r;
    t[79:76]   = inv_sbox(t[79:76]);
    return {t[60:0], t[79:61]};
  endfunction

  // Forward pLayer moves bit i to 16*i mod 63, so the inverse gathers from there.
  function automatic logic [63:0] inv_p_layer(input logic [63:0] s);
    logic [63:0] o;
    for (int i = 0; i < 63; i++) begin
      o[i] = s[(16 * i) % 63];
    end
    o[63] = s[63];
    return o;
  endfunction

  function automatic logic [63:0] inv_s_layer(input logic [63:0] s);
    logic [63:0] o;
    for (int n = 0; n < 16; n++) begin
      o[4 * n +: 4] = inv_sbox(s[4 * n +: 4]);
    end
    return o;
  endfunction

  logic [1:0]  fsm;
  logic [4:0]  rnd;
  logic [63:0] state_reg;
  logic [79:0] key_reg;
  logic [79:0] key_lat;
  logic [79:0] cached_key;
  logic [79:0] cached_k32;
  logic        cache_valid;
  logic        key_hit;
  logic [79:0] key_next_fwd;

  assign key_hit      = (KEY_CACHE != 0) && cache_valid && (key == cached_key);
  assign key_next_fwd = fwd_update(key_reg, rnd);

  // NOTE: every register below is state, so it is written with <= only; a
  // blocking assignment here would let later reads in the same block see the
  // new value and silently change the datapath timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= S_IDLE;
      rnd         <= '0;
      state_reg   <= '0;
      key_reg     <= '0;
      key_lat     <= '0;
      // NOTE: the cache contents are cleared along with the valid flag so a
      // reset leaves no trace of the previous key in the core.
      cached_key  <= '0;
      cached_k32  <= '0;
      cache_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pt          <= '0;
    end else begin
      done <= 1'b0;
      case (fsm)
        S_IDLE: begin
          if (start) begin
            state_reg <= ct;
            key_lat   <= key;
            busy      <= 1'b1;
            if (key_hit) begin
              key_reg <= cached_k32;
              rnd     <= 5'd31;
              fsm     <= S_DEC;
            end else begin
              key_reg <= key;
              rnd     <= 5'd1;
              fsm     <= S_KEXP;
            end
          end
        end

        S_KEXP: begin
          key_reg <= key_next_fwd;
          rnd     <= rnd + 5'd1;
          if (rnd == 5'd31) begin
            // Schedule has reached K32: decryption starts from the top round.
            rnd        <= 5'd31;
            fsm        <= S_DEC;
            cached_k32 <= key_next_fwd;
            cached_key <= key_lat;
            if (KEY_CACHE != 0) cache_valid <= 1'b1;
          end
        end

        S_DEC: begin
          state_reg <= inv_s_layer(inv_p_layer(state_reg ^ key_reg[79:16]));
          key_reg   <= inv_update(key_reg, rnd);
          rnd       <= rnd - 5'd1;
          if (rnd == 5'd1) fsm <= S_FINAL;
        end

        default: begin  // S_FINAL: key_reg now holds K1 for the last whitening
          pt   <= state_reg ^ key_reg[79:16];
          done <= 1'b1;
          busy <= 1'b0;
          fsm  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_present80_dec_core.sv
// ---------------------------------------------------------------------------
// tb_present80_dec_core
//   Self-checking bench for present80_dec_core. Known PRESENT-80 vectors check
//   the key-schedule and cache behaviour. A bit-level PRESENT-80 encryptor
//   supplies the loopback reference. A second instance with the cache disabled
//   checks the always-expand latency.
// ---------------------------------------------------------------------------
module tb_present80_dec_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [63:0] ct;
  logic [79:0] key;
  logic [63:0] pt;

  logic        nc_start;
  logic        nc_busy;
  logic        nc_done;
  logic [63:0] nc_ct;
  logic [79:0] nc_key;
  logic [63:0] nc_pt;

  int errors = 0;
  int checks = 0;

  // Reference view of the key cache in the cached instance.
  bit          cache_ok = 1'b0;
  logic [79:0] cache_key = '0;

  always #5 clk = ~clk;

  present80_dec_core #(.KEY_CACHE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .ct(ct), .key(key), .pt(pt)
  );

  present80_dec_core #(.KEY_CACHE(0)) dut_nc (
    .clk(clk), .rst(rst), .start(nc_start), .busy(nc_busy), .done(nc_done),
    .ct(nc_ct), .key(nc_key), .pt(nc_pt)
  );

  localparam logic [3:0] SBOX_TBL [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  // Textbook PRESENT-80 encryption, used to build loopback ciphertexts.
  function automatic logic [63:0] ref_encrypt(input logic [63:0] p,
                                              input logic [79:0] k);
    logic [63:0] s;
    logic [63:0] t;
    logic [79:0] kk;
    s  = p;
    kk = k;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ kk[79:16];
      for (int n = 0; n < 16; n++) s[4 * n +: 4] = SBOX_TBL[s[4 * n +: 4]];
      t = '0;
      for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : (b * 16) % 63] = s[b];
      s  = t;
      kk = (kk << 61) | (kk >> 19);
      kk[79:76] = SBOX_TBL[kk[79:76]];
      kk[19:15] = kk[19:15] ^ r[4:0];
    end
    return s ^ kk[79:16];
  endfunction

  function automatic logic [79:0] rand_key();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  // Issue one operation on the cached instance. Returns at 1 time unit after
  // the done edge, so a following call starts on the done cycle.
  task automatic run_op(input logic [63:0] c, input logic [79:0] k,
                        input logic [63:0] exp_pt, input int exp_lat,
                        input string name, input bit inject);
    int lat;
    bit bad_hs;
    ct    = c;
    key   = k;
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    lat    = 0;
    bad_hs = 1'b0;
    for (int n = 1; n <= 100 && lat == 0; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = n;
        if (busy !== 1'b0) bad_hs = 1'b1;
      end else if (busy !== 1'b1 || done !== 1'b0) begin
        bad_hs = 1'b1;
      end
      if (inject) begin
        if (n == 5 || n == 40) begin
          start = 1'b1;
          ct    = {$urandom, $urandom};
          key   = rand_key();
        end else begin
          start = 1'b0;
        end
      end
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d (0 = timeout)", name, lat, exp_lat);
    end
    checks++;
    if (pt !== exp_pt) begin
      errors++;
      $display("FAIL %s pt: got %h expected %h", name, pt, exp_pt);
    end
    checks++;
    if (bad_hs) begin
      errors++;
      $display("FAIL %s handshake: got busy/done out of step, expected busy high until done", name);
    end
    if (lat != 0) begin
      cache_ok  = 1'b1;
      cache_key = k;
    end
  endtask

  task automatic nc_run(input logic [63:0] c, input logic [79:0] k,
                        input logic [63:0] exp_pt, input string name);
    int lat;
    nc_ct    = c;
    nc_key   = k;
    nc_start = 1'b1;
    @(posedge clk);
    #1;
    nc_start = 1'b0;
    lat      = 0;
    for (int n = 1; n <= 100 && lat == 0; n++) begin
      @(posedge clk);
      #1;
      if (nc_done === 1'b1) lat = n;
    end
    checks++;
    if (lat != 63) begin
      errors++;
      $display("FAIL %s latency: got %0d expected 63 (0 = timeout)", name, lat);
    end
    checks++;
    if (nc_pt !== exp_pt) begin
      errors++;
      $display("FAIL %s pt: got %h expected %h", name, nc_pt, exp_pt);
    end
  endtask

  // Watch for a spurious completion over a window of cycles.
  task automatic expect_quiet(input int cycles, input string name);
    int pulses;
    pulses = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL %s extra done pulses: got %0d expected 0", name, pulses);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b0;
    ct       = '0;
    key      = '0;
    nc_start = 1'b0;
    nc_ct    = '0;
    nc_key   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    cache_ok = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset busy/done: got %b expected 00", {busy, done});
    end
    checks++;
    if (pt !== 64'h0) begin
      errors++;
      $display("FAIL reset pt: got %h expected 0", pt);
    end
    checks++;
    if ({nc_busy, nc_done, nc_pt} !== 66'h0) begin
      errors++;
      $display("FAIL reset nocache outputs: got %h expected 0", {nc_busy, nc_done, nc_pt});
    end
  endtask

  task automatic test_cold_and_hit();
    run_op(64'h5579C1387B228445, 80'h0, 64'h0, 63, "cold_miss", 1'b0);
    // Start on the done cycle: key 0 is now cached.
    run_op(64'hA112FFC72F68417B, 80'h0, 64'hFFFFFFFFFFFFFFFF, 32, "cache_hit", 1'b0);
    expect_quiet(3, "after_hit");
  endtask

  task automatic test_no_cache();
    nc_run(64'h5579C1387B228445, 80'h0, 64'h0, "nocache_first");
    nc_run(64'hA112FFC72F68417B, 80'h0, 64'hFFFFFFFFFFFFFFFF, "nocache_repeat");
  endtask

  task automatic test_key_change();
    run_op(64'hE72C46C0F5945049, {80{1'b1}}, 64'h0, 63, "key_change", 1'b0);
    run_op(64'h3333DCD3213210D2, {80{1'b1}}, 64'hFFFFFFFFFFFFFFFF, 32, "key_repeat", 1'b0);
  endtask

  task automatic test_ignored_inputs();
    run_op(64'h5579C1387B228445, 80'h0, 64'h0, 63, "ignored_inputs", 1'b1);
    expect_quiet(70, "ignored_inputs");
  endtask

  task automatic test_reset_mid_run();
    ct    = 64'hE72C46C0F5945049;
    key   = {80{1'b1}};
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (40) @(posedge clk);  // well into the decryption rounds
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    cache_ok = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00 || pt !== 64'h0) begin
      errors++;
      $display("FAIL mid_reset outputs: got busy=%b done=%b pt=%h expected 0 0 0", busy, done, pt);
    end
    expect_quiet(70, "mid_reset");
    run_op(64'hE72C46C0F5945049, {80{1'b1}}, 64'h0, 63, "post_reset_miss", 1'b0);
  endtask

  task automatic test_loopback();
    logic [79:0] k;
    logic [63:0] p;
    int          lat;
    k = rand_key();
    for (int i = 0; i < 200; i++) begin
      if (i % 4 == 0) k = rand_key();
      p   = {$urandom, $urandom};
      lat = (cache_ok && k == cache_key) ? 32 : 63;
      run_op(ref_encrypt(p, k), k, p, lat, $sformatf("loopback_%0d", i), 1'b0);
    end
    expect_quiet(3, "loopback_end");
  endtask

  initial begin
    test_reset();
    test_cold_and_hit();
    test_no_cache();
    test_key_change();
    test_ignored_inputs();
    test_reset_mid_run();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
